// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: matches a loadable DEPTH-symbol pattern on a valid-qualified symbol stream.
// Optional sticky match flag enabled by defining SEQ_DET_STICKY_EN.
module seq_pattern_detector #(
  parameter int SYM_W = 1,
  parameter int DEPTH = 5,
  parameter int CNT_W = 8,
  parameter logic [DEPTH*SYM_W-1:0] RST_PATTERN = {DEPTH*SYM_W{1'b1}}
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   load_i,
  input  logic [DEPTH*SYM_W-1:0] pattern_i,
  input  logic                   overlap_i,
  input  logic                   valid_i,
  input  logic [SYM_W-1:0]       sym_i,
`ifdef SEQ_DET_STICKY_EN
  input  logic                   sticky_clr_i,
  output logic                   sticky_o,
`endif
  output logic                   det_o,
  output logic [CNT_W-1:0]       cnt_o
);

  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

  logic [DEPTH*SYM_W-1:0] pat_q;
  logic [DEPTH*SYM_W-1:0] hist_q;
  logic [DEPTH*SYM_W-1:0] hist_n;
  logic [FILL_W-1:0]      fill_q;
  logic [FILL_W-1:0]      fill_n;
  logic                   match_n;

  // Newest symbol always enters at slice 0.
  generate
    if (DEPTH == 1) begin : g_hist_single
      assign hist_n = sym_i;
    end else begin : g_hist_shift
      assign hist_n = {hist_q[(DEPTH-1)*SYM_W-1:0], sym_i};
    end
  endgenerate

  always_comb begin
    fill_n  = fill_q;
    match_n = 1'b0;
    // In non-overlap mode the symbol following a match starts a fresh window.
    if (det_o && !overlap_i) begin
      fill_n = FILL_W'(1);
    end else if (fill_q < FILL_FULL) begin
      fill_n = fill_q + 1'b1;
    end
    match_n = (fill_n == FILL_FULL) && (hist_n == pat_q);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pat_q  <= RST_PATTERN;
      hist_q <= '0;
      fill_q <= '0;
      det_o  <= 1'b0;
      cnt_o  <= '0;
    end else if (load_i) begin
      pat_q  <= pattern_i;
      hist_q <= '0;
      fill_q <= '0;
      det_o  <= 1'b0;
      cnt_o  <= '0;
    end else if (valid_i) begin
      hist_q <= hist_n;
      fill_q <= fill_n;
      det_o  <= match_n;
      if (match_n && (cnt_o != {CNT_W{1'b1}})) begin
        cnt_o <= cnt_o + 1'b1;
      end
    end
  end

`ifdef SEQ_DET_STICKY_EN
  // A match on the same edge as a clear request keeps the flag set.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sticky_o <= 1'b0;
    end else if (load_i) begin
      sticky_o <= 1'b0;
    end else if (valid_i && match_n) begin
      sticky_o <= 1'b1;
    end else if (sticky_clr_i) begin
      sticky_o <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench for seq_pattern_detector: directed scenarios plus randomized traffic
// against a window-based reference model; two instances (default and 4-bit/depth-3/2-bit counter).
module tb_seq_pattern_detector;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic       load0 = 1'b0, ovl0 = 1'b1, val0 = 1'b0, sym0 = 1'b0, sclr0 = 1'b0;
  logic [4:0] pat0 = '0;
  logic       det0;
  logic [7:0] cnt0;

  logic        load1 = 1'b0, ovl1 = 1'b1, val1 = 1'b0, sclr1 = 1'b0;
  logic [3:0]  sym1 = '0;
  logic [11:0] pat1 = '0;
  logic        det1;
  logic [1:0]  cnt1;

`ifdef SEQ_DET_STICKY_EN
  logic stk0, stk1;
`endif

  int errors = 0;
  int checks = 0;

  seq_pattern_detector u_dut0 (
    .clk_i(clk), .rstn_i(rstn), .load_i(load0), .pattern_i(pat0), .overlap_i(ovl0),
    .valid_i(val0), .sym_i(sym0),
`ifdef SEQ_DET_STICKY_EN
    .sticky_clr_i(sclr0), .sticky_o(stk0),
`endif
    .det_o(det0), .cnt_o(cnt0)
  );

  seq_pattern_detector #(.SYM_W(4), .DEPTH(3), .CNT_W(2)) u_dut1 (
    .clk_i(clk), .rstn_i(rstn), .load_i(load1), .pattern_i(pat1), .overlap_i(ovl1),
    .valid_i(val1), .sym_i(sym1),
`ifdef SEQ_DET_STICKY_EN
    .sticky_clr_i(sclr1), .sticky_o(stk1),
`endif
    .det_o(det1), .cnt_o(cnt1)
  );

  // Reference model: keeps the most recent symbols as a list plus the number of
  // symbols seen since the current window started; a match needs a full window.
  int m_seg [2];
  int m_last[2][8];
  int m_pat [2][8];
  bit m_det [2];
  int m_cnt [2];
  bit m_stk [2];

  task automatic model_reset(input int i);
    int w = (i == 0) ? 1 : 4;
    int d = (i == 0) ? 5 : 3;
    for (int k = 0; k < 8; k++) begin
      m_last[i][k] = 0;
      m_pat[i][k]  = (k < d) ? ((1 << w) - 1) : 0;
    end
    m_seg[i] = 0; m_det[i] = 1'b0; m_cnt[i] = 0; m_stk[i] = 1'b0;
  endtask

  task automatic model_step(input int i, input bit ld, input bit v, input int sym,
                            input bit ov, input bit clr, input int pattern);
    int  w    = (i == 0) ? 1 : 4;
    int  d    = (i == 0) ? 5 : 3;
    int  cmax = (i == 0) ? 255 : 3;
    bit  match;
    if (ld) begin
      for (int k = 0; k < 8; k++) begin
        m_last[i][k] = 0;
        m_pat[i][k]  = (k < d) ? ((pattern >> (k * w)) & ((1 << w) - 1)) : 0;
      end
      m_seg[i] = 0; m_det[i] = 1'b0; m_cnt[i] = 0; m_stk[i] = 1'b0;
    end else if (v) begin
      for (int k = 7; k > 0; k--) m_last[i][k] = m_last[i][k-1];
      m_last[i][0] = sym;
      if (m_det[i] && !ov) m_seg[i] = 1;
      else m_seg[i] = m_seg[i] + 1;
      match = (m_seg[i] >= d);
      for (int k = 0; k < d; k++) if (m_last[i][k] != m_pat[i][k]) match = 1'b0;
      m_det[i] = match;
      if (match && m_cnt[i] < cmax) m_cnt[i] = m_cnt[i] + 1;
      if (match) m_stk[i] = 1'b1;
      else if (clr) m_stk[i] = 1'b0;
    end else if (clr) begin
      m_stk[i] = 1'b0;
    end
  endtask

  task automatic tick();
    model_step(0, load0, val0, int'(sym0), ovl0, sclr0, int'(pat0));
    model_step(1, load1, val1, int'(sym1), ovl1, sclr1, int'(pat1));
    @(posedge clk);
    #1;
  endtask

  task automatic load_both(input logic [4:0] p0, input logic [11:0] p1);
    load0 = 1'b1; pat0 = p0; val0 = 1'b0;
    load1 = 1'b1; pat1 = p1; val1 = 1'b0;
    tick();
    load0 = 1'b0; load1 = 1'b0;
  endtask

  task automatic test_reset();
    #1 rstn = 1'b0;
    #1;
    checks++; if (det0 !== 1'b0) begin errors++; $display("FAIL reset_det0 got=%b exp=0", det0); end
    checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL reset_cnt0 got=%0d exp=0", cnt0); end
    checks++; if (det1 !== 1'b0) begin errors++; $display("FAIL reset_det1 got=%b exp=0", det1); end
    checks++; if (cnt1 !== 2'd0) begin errors++; $display("FAIL reset_cnt1 got=%0d exp=0", cnt1); end
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    model_reset(0); model_reset(1);
    $display("test_reset done");
  endtask

  // Uses the reset pattern (all ones) with no load beforehand.
  task automatic test_overlap();
    ovl0 = 1'b1; val0 = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      sym0 = (n <= 7);
      tick();
      checks++;
      if (det0 !== ((n >= 5) && (n <= 7))) begin
        errors++; $display("FAIL overlap_det n=%0d got=%b exp=%b", n, det0, (n >= 5) && (n <= 7));
      end
      $display("overlap sym#%0d=%b det=%b cnt=%0d", n, sym0, det0, cnt0);
    end
    checks++; if (cnt0 !== 8'd3) begin errors++; $display("FAIL overlap_cnt got=%0d exp=3", cnt0); end
    val0 = 1'b0;
  endtask

  task automatic test_non_overlap();
    load_both(5'h1f, 12'hfff);
    ovl0 = 1'b0; val0 = 1'b1; sym0 = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      checks++;
      if (det0 !== ((n == 5) || (n == 10))) begin
        errors++; $display("FAIL nonovl_det n=%0d got=%b exp=%b", n, det0, (n == 5) || (n == 10));
      end
      $display("nonoverlap sym#%0d det=%b cnt=%0d", n, det0, cnt0);
    end
    checks++; if (cnt0 !== 8'd2) begin errors++; $display("FAIL nonovl_cnt got=%0d exp=2", cnt0); end
    val0 = 1'b0; ovl0 = 1'b1;
  endtask

  task automatic test_valid_gap();
    logic vpat [13] = '{1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 1};
    logic epat [13] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    load_both(5'h1f, 12'hfff);
    sym0 = 1'b1;
    for (int n = 0; n < 13; n++) begin
      val0 = vpat[n];
      tick();
      checks++; if (det0 !== epat[n]) begin errors++; $display("FAIL gap_det step=%0d got=%b exp=%b", n, det0, epat[n]); end
      $display("gap step=%0d valid=%b det=%b cnt=%0d", n, val0, det0, cnt0);
    end
    checks++; if (cnt0 !== 8'd4) begin errors++; $display("FAIL gap_cnt got=%0d exp=4", cnt0); end
    // An intervening zero must break the run.
    load_both(5'h1f, 12'hfff);
    val0 = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      sym0 = (n != 3);
      tick();
      checks++; if (det0 !== (n == 8)) begin errors++; $display("FAIL gap_zero_det n=%0d got=%b exp=%b", n, det0, n == 8); end
    end
    val0 = 1'b0;
  endtask

  task automatic test_wide_pattern();
    logic [3:0] s [5] = '{4'hA, 4'hB, 4'hA, 4'hB, 4'hC};
    load_both(5'h1f, 12'hABC);
    ovl1 = 1'b1; val1 = 1'b1;
    for (int n = 0; n < 5; n++) begin
      sym1 = s[n];
      tick();
      checks++; if (det1 !== (n == 4)) begin errors++; $display("FAIL wide_det n=%0d got=%b exp=%b", n, det1, n == 4); end
      $display("wide sym=%h det=%b cnt=%0d", sym1, det1, cnt1);
    end
    checks++; if (cnt1 !== 2'd1) begin errors++; $display("FAIL wide_cnt got=%0d exp=1", cnt1); end
    val1 = 1'b0;
  endtask

  task automatic test_saturate();
    int exp_cnt;
    load_both(5'h1f, 12'hfff);
    val1 = 1'b1; sym1 = 4'hf;
    for (int n = 1; n <= 7; n++) begin
      tick();
      exp_cnt = (n < 3) ? 0 : ((n - 2 > 3) ? 3 : n - 2);
      checks++; if (cnt1 !== 2'(exp_cnt)) begin errors++; $display("FAIL sat_cnt n=%0d got=%0d exp=%0d", n, cnt1, exp_cnt); end
      $display("saturate sym#%0d det=%b cnt=%0d", n, det1, cnt1);
    end
    // Load with a concurrent valid symbol: the symbol must be discarded.
    load1 = 1'b1; pat1 = 12'hfff;
    tick();
    load1 = 1'b0;
    checks++; if (cnt1 !== 2'd0) begin errors++; $display("FAIL loadprio_cnt got=%0d exp=0", cnt1); end
    checks++; if (det1 !== 1'b0) begin errors++; $display("FAIL loadprio_det got=%b exp=0", det1); end
    for (int n = 1; n <= 3; n++) begin
      tick();
      checks++; if (det1 !== (n == 3)) begin errors++; $display("FAIL loadprio_fill n=%0d got=%b exp=%b", n, det1, n == 3); end
    end
    val1 = 1'b0;
  endtask

  task automatic test_reset_midrun();
    // All-zero pattern: a partial (all-zero) history must not match.
    load_both(5'h00, 12'hfff);
    val0 = 1'b1; sym0 = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      tick();
      checks++; if (det0 !== (n == 5)) begin errors++; $display("FAIL zero_pat_det n=%0d got=%b exp=%b", n, det0, n == 5); end
    end
    sym0 = 1'b1;
    for (int n = 1; n <= 4; n++) tick();
    val0 = 1'b0;
    rstn = 1'b0;
    #1;
    checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL midrst_cnt got=%0d exp=0", cnt0); end
    checks++; if (det0 !== 1'b0) begin errors++; $display("FAIL midrst_det got=%b exp=0", det0); end
    @(posedge clk); #1;
    rstn = 1'b1;
    model_reset(0); model_reset(1);
    val0 = 1'b1; sym0 = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      tick();
      checks++; if (det0 !== (n == 5)) begin errors++; $display("FAIL postrst_det n=%0d got=%b exp=%b", n, det0, n == 5); end
      $display("post-reset one#%0d det=%b", n, det0);
    end
`ifdef SEQ_DET_STICKY_EN
    checks++; if (stk0 !== 1'b1) begin errors++; $display("FAIL sticky_set got=%b exp=1", stk0); end
    sclr0 = 1'b1;
    tick();
    checks++; if (stk0 !== 1'b1) begin errors++; $display("FAIL sticky_setwins got=%b exp=1", stk0); end
    val0 = 1'b0;
    tick();
    sclr0 = 1'b0;
    checks++; if (stk0 !== 1'b0) begin errors++; $display("FAIL sticky_clr got=%b exp=0", stk0); end
`endif
    val0 = 1'b0;
  endtask

  task automatic test_random();
    logic [11:0] p1;
    for (int c = 0; c < 600; c++) begin
      load0 = ($urandom_range(0, 49) == 0);
      load1 = ($urandom_range(0, 49) == 0);
      pat0  = 5'($urandom);
      p1    = '0;
      for (int k = 0; k < 3; k++) p1[k*4 +: 4] = 4'($urandom_range(0, 1));
      pat1  = p1;
      ovl0  = 1'($urandom); ovl1 = 1'($urandom);
      val0  = ($urandom_range(0, 3) != 0); val1 = ($urandom_range(0, 3) != 0);
      sym0  = ($urandom_range(0, 4) != 0) ? pat0[0] ^ 1'($urandom_range(0, 1)) : 1'b1;
      sym1  = 4'($urandom_range(0, 1));
      sclr0 = ($urandom_range(0, 9) == 0); sclr1 = ($urandom_range(0, 9) == 0);
      tick();
      checks++; if (det0 !== m_det[0]) begin errors++; $display("FAIL rnd_det0 cyc=%0d got=%b exp=%b", c, det0, m_det[0]); end
      checks++; if (cnt0 !== 8'(m_cnt[0])) begin errors++; $display("FAIL rnd_cnt0 cyc=%0d got=%0d exp=%0d", c, cnt0, m_cnt[0]); end
      checks++; if (det1 !== m_det[1]) begin errors++; $display("FAIL rnd_det1 cyc=%0d got=%b exp=%b", c, det1, m_det[1]); end
      checks++; if (cnt1 !== 2'(m_cnt[1])) begin errors++; $display("FAIL rnd_cnt1 cyc=%0d got=%0d exp=%0d", c, cnt1, m_cnt[1]); end
`ifdef SEQ_DET_STICKY_EN
      checks++; if (stk0 !== m_stk[0]) begin errors++; $display("FAIL rnd_stk0 cyc=%0d got=%b exp=%b", c, stk0, m_stk[0]); end
      checks++; if (stk1 !== m_stk[1]) begin errors++; $display("FAIL rnd_stk1 cyc=%0d got=%b exp=%b", c, stk1, m_stk[1]); end
`endif
      if (c % 50 == 0) $display("random cyc=%0d det0=%b cnt0=%0d det1=%b cnt1=%0d", c, det0, cnt0, det1, cnt1);
    end
    load0 = 1'b0; load1 = 1'b0; val0 = 1'b0; val1 = 1'b0; sclr0 = 1'b0; sclr1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_valid_gap();
    test_wide_pattern();
    test_saturate();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
